lpddr4_ca_sequencer: RTL and testbench
======================================

// Module: lpddr4_ca_sequencer
// PURPOSE
// Command/address sequencer for the LPDDR4-4266 controller pin interface (ddrxctl).
// Accepts one abstract DRAM command per valid/ready handshake and serialises it into
// multi-tick LPDDR4 CS/CA patterns; drives cke through power-up.
// Per-bank/global timing guards hold off commands so downstream pin timing holds by construction.
// PARAMETERS
// T_RCD   18   cycles, ACT last tick -> RD/WR to same bank
// T_RP    18   cycles, PRE/PREA last tick -> ACT to affected bank(s)
// T_RFC   120  cycles, REF last tick -> any command
// T_CCD   8    cycles, RD/WR last tick -> next RD/WR
// CKE_INIT 16  cycles cke held low after reset release
// PORTS
// ck         in   1   controller clock (CA tick rate)
// rst        in   1   asynchronous active-high reset
// req_valid  in   1   command request valid
// req_ready  out  1   request accepted when valid&&ready
// req_cmd    in   3   0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 PREA,6 REF(all-bank),7 rsvd
// req_bank   in   3   BA[2:0]
// req_row    in   16  R[15:0] (ACT only)
// req_col    in   10  C[9:0]; C1:C0 ignored (RD/WR only)
// cs         out  1   chip select to pin stage
// ca         out  6   CA[5:0], ca[0]=CA0
// cke        out  1   clock enable
// cmd_err    out  1   1-cycle pulse: illegal command dropped
// busy       out  1   high in INIT or while a pattern is being emitted
// BEHAVIOUR
// - Reset: cs=0, ca=0, cke=0, req_ready=0, cmd_err=0, busy=1, all banks closed, all counters 0, state INIT.
// - All outputs registered. FSM: INIT -> IDLE -> EMIT(tick 0..N-1) -> IDLE.
// - INIT: count CKE_INIT cycles; cke=1 on the cycle INIT exits; cke stays 1 until rst.
// - IDLE: req_ready=1 iff the presented cmd's guards are 0: ACT bank tRP; RD/WR bank tRCD and tCCD;
//   PRE bank-independent; all cmds need tRFC=0. NOP/rsvd: ready=1, accepted, nothing emitted.
// - Legality checked at acceptance: RD/WR to closed bank, ACT to open bank, REF with any bank open,
//   rsvd -> cmd_err=1 next cycle, no CA emitted, bank state unchanged.
// - Legal accept: tick0 appears on cs/ca the next cycle; ready=0 until last tick done.
//   N=4 for ACT/RD/WR, N=2 for PRE/PREA/REF. cs=1 on ticks 0 and 2, 0 elsewhere; DES (cs=0, ca=0) when idle.
// - Encodings ca[5:0] (tick0/tick1/tick2/tick3):
//   ACT : {R15..R12,0,1} / {R11,R10,0,BA} / {R9..R6,1,1} / R[5:0]
//   RD  : 6'b000010 / {0,C9,0,BA} / {C8,1,0,0,1,0} / C[7:2]
//   WR  : 6'b000100 / {0,C9,0,BA} / {C8,1,0,0,1,0} / C[7:2]
//   PRE : 6'b010000 / {3'b000,BA};  PREA: 6'b110000 / 0;  REF: 6'b101000 / 0
// - Bank state update and guard load on the last tick: ACT opens bank, loads tRCD[bank];
//   PRE closes bank, loads tRP[bank]; PREA closes all, loads every tRP; RD/WR loads tCCD;
//   REF loads tRFC. A guard loaded with T means T further cycles before the dependent cmd may be accepted.
// - Guards are 8-bit (tRFC 10-bit) down-counters, saturate at 0, never wrap; parameter > width is an elaboration error.
// - PRE to closed bank is legal (NOP-like); still emitted and reloads tRP.
// - Async rst mid-pattern: outputs to reset values immediately; partial pattern abandoned; restart via INIT.
// STRUCTURE
// - Package lpddr4_ca_pkg: cmd enum, tick-0 opcode constants, state enum, function encode_tick(cmd,bank,row,col,tick).
// - Sub-module lpddr4_timing_guard: per-bank tRCD/tRP + global tCCD/tRFC counters and open-bank bitmap;
//   outputs per-command ok flags.
// - Top holds FSM, request capture register, output registers.
// TESTING
// - Reset release: cke=0 for 16 cycles then 1; req_ready 0 until IDLE; cs/ca stay 0.
// - ACT bank3 row 16'hABCD: ca 101001,100011,111111,001101; cs 1,0,1,0; bank3 open.
// - RD bank3 col 10'h3FC immediately after that ACT: ready low 18 cycles, then accepted;
//   ca 000010,010011,110010,111111.
// - RD to closed bank 5: cmd_err one cycle, cs/ca stay DES, bank map unchanged.
// - PREA then REF: REF held off 18 cycles (tRP); REF emits 101000,000000; next ACT held 120 cycles.
// - rst asserted on tick 1 of an ACT: cs/ca/cke to 0 same cycle; after release bank map empty,
//   full INIT repeated.

Source files
------------

// File: rtl/lpddr4_ca_pkg.sv
// rtl/lpddr4_ca_pkg.sv - command, state and CA tick encoding shared by the LPDDR4 CA sequencer
package lpddr4_ca_pkg;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_ACT  = 3'd1,
      CMD_RD   = 3'd2,
      CMD_WR   = 3'd3,
      CMD_PRE  = 3'd4,
      CMD_PREA = 3'd5,
      CMD_REF  = 3'd6,
      CMD_RSVD = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_EMIT
   } state_e;

   localparam logic [5:0] OP_RD   = 6'b000010;
   localparam logic [5:0] OP_WR   = 6'b000100;
   localparam logic [5:0] OP_PRE  = 6'b010000;
   localparam logic [5:0] OP_PREA = 6'b110000;
   localparam logic [5:0] OP_REF  = 6'b101000;

   function automatic logic [1:0] last_tick(input cmd_e cmd);
      return (cmd == CMD_ACT || cmd == CMD_RD || cmd == CMD_WR) ? 2'd3 : 2'd1;
   endfunction

   function automatic logic [5:0] encode_tick(input cmd_e cmd, input logic [2:0] bank,
                                              input logic [15:0] row, input logic [9:0] col,
                                              input logic [1:0] tick);
      logic [5:0] v;
      v = 6'd0;
      case (cmd)
         CMD_ACT: begin
            case (tick)
               2'd0:    v = {row[15:12], 2'b01};
               2'd1:    v = {row[11:10], 1'b0, bank};
               2'd2:    v = {row[9:6], 2'b11};
               default: v = row[5:0];
            endcase
         end
         CMD_RD, CMD_WR: begin
            case (tick)
               2'd0:    v = (cmd == CMD_RD) ? OP_RD : OP_WR;
               2'd1:    v = {1'b0, col[9], 1'b0, bank};
               2'd2:    v = {col[8], 5'b10010};
               default: v = col[7:2];
            endcase
         end
         CMD_PRE:  v = (tick == 2'd0) ? OP_PRE : {3'b000, bank};
         CMD_PREA: v = (tick == 2'd0) ? OP_PREA : 6'd0;
         CMD_REF:  v = (tick == 2'd0) ? OP_REF : 6'd0;
         default:  v = 6'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/lpddr4_timing_guard.sv
// rtl/lpddr4_timing_guard.sv - per-bank tRCD/tRP and global tCCD/tRFC guards plus open-bank map
module lpddr4_timing_guard
   import lpddr4_ca_pkg::*;
#(
   parameter int T_RCD = 18,
   parameter int T_RP  = 18,
   parameter int T_RFC = 120,
   parameter int T_CCD = 8
)(
   input  logic       ck,
   input  logic       rst,
   input  logic       load_act,
   input  logic       load_pre,
   input  logic       load_prea,
   input  logic       load_rdwr,
   input  logic       load_ref,
   input  logic [2:0] load_bank,
   input  logic [2:0] req_bank,
   output logic [7:0] open_map,
   output logic       act_ok,
   output logic       rdwr_ok,
   output logic       ref_ok,
   output logic       rfc_ok
);

   if (T_RCD > 255 || T_RP > 255 || T_CCD > 255 || T_RFC > 1023) begin : g_range_err
      $error("lpddr4_timing_guard: timing parameter exceeds guard counter width");
   end

   localparam logic [7:0] RCD_LD = 8'(T_RCD);
   localparam logic [7:0] RP_LD  = 8'(T_RP);
   localparam logic [7:0] CCD_LD = 8'(T_CCD);
   localparam logic [9:0] RFC_LD = 10'(T_RFC);

   logic [7:0] trcd [8];
   logic [7:0] trp  [8];
   logic [7:0] tccd;
   logic [9:0] trfc;

   // A load wins over the decrement, so a guard holds exactly T cycles after its last tick.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         open_map <= 8'd0;
         tccd     <= 8'd0;
         trfc     <= 10'd0;
         for (int i = 0; i < 8; i++) begin
            trcd[i] <= 8'd0;
            trp[i]  <= 8'd0;
         end
      end else begin
         tccd <= load_rdwr ? CCD_LD : ((tccd != 8'd0) ? tccd - 8'd1 : 8'd0);
         trfc <= load_ref  ? RFC_LD : ((trfc != 10'd0) ? trfc - 10'd1 : 10'd0);
         for (int i = 0; i < 8; i++) begin
            if (load_act && load_bank == 3'(i)) begin
               trcd[i]     <= RCD_LD;
               open_map[i] <= 1'b1;
            end else if (trcd[i] != 8'd0) begin
               trcd[i] <= trcd[i] - 8'd1;
            end
            if (load_prea || (load_pre && load_bank == 3'(i))) begin
               trp[i]      <= RP_LD;
               open_map[i] <= 1'b0;
            end else if (trp[i] != 8'd0) begin
               trp[i] <= trp[i] - 8'd1;
            end
         end
      end
   end

   always_comb begin
      ref_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (trp[i] != 8'd0) ref_ok = 1'b0;
      end
   end

   assign act_ok  = (trp[req_bank] == 8'd0);
   assign rdwr_ok = (trcd[req_bank] == 8'd0) && (tccd == 8'd0);
   assign rfc_ok  = (trfc == 10'd0);

endmodule

// File: rtl/lpddr4_ca_sequencer.sv
// rtl/lpddr4_ca_sequencer.sv - serialises abstract DRAM commands into LPDDR4 CS/CA tick patterns
module lpddr4_ca_sequencer
   import lpddr4_ca_pkg::*;
#(
   parameter int T_RCD    = 18,
   parameter int T_RP     = 18,
   parameter int T_RFC    = 120,
   parameter int T_CCD    = 8,
   parameter int CKE_INIT = 16
)(
   input  logic        ck,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cmd,
   input  logic [2:0]  req_bank,
   input  logic [15:0] req_row,
   input  logic [9:0]  req_col,
   output logic        cs,
   output logic [5:0]  ca,
   output logic        cke,
   output logic        cmd_err,
   output logic        busy
);

   localparam logic [7:0] INIT_LAST = 8'(CKE_INIT - 1);

   state_e      state;
   logic [7:0]  init_cnt;
   logic [1:0]  tick;
   cmd_e        cap_cmd;
   logic [2:0]  cap_bank;
   logic [15:0] cap_row;
   logic [9:0]  cap_col;

   logic [7:0]  open_map;
   logic        act_ok, rdwr_ok, ref_ok, rfc_ok;
   cmd_e        cur_cmd;
   logic        cmd_ok, illegal, accept, go, last;

   assign cur_cmd = cmd_e'(req_cmd);

   always_comb begin
      cmd_ok  = 1'b1;
      illegal = 1'b0;
      case (cur_cmd)
         CMD_ACT:           begin cmd_ok = act_ok & rfc_ok;  illegal = open_map[req_bank];  end
         CMD_RD, CMD_WR:    begin cmd_ok = rdwr_ok & rfc_ok; illegal = ~open_map[req_bank]; end
         CMD_PRE, CMD_PREA: cmd_ok = rfc_ok;
         CMD_REF:           begin cmd_ok = ref_ok & rfc_ok;  illegal = |open_map;           end
         CMD_RSVD:          illegal = 1'b1;
         default:           cmd_ok = 1'b1;
      endcase
   end

   // Ready follows the presented command so a source may retarget while waiting.
   assign req_ready = (state == ST_IDLE) && cmd_ok;
   assign accept    = req_valid && req_ready;
   assign go        = accept && !illegal && (cur_cmd != CMD_NOP);
   assign last      = (state == ST_EMIT) && (tick == last_tick(cap_cmd));

   lpddr4_timing_guard #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RFC (T_RFC),
      .T_CCD (T_CCD)
   ) u_guard (
      .ck        (ck),
      .rst       (rst),
      .load_act  (last && cap_cmd == CMD_ACT),
      .load_pre  (last && cap_cmd == CMD_PRE),
      .load_prea (last && cap_cmd == CMD_PREA),
      .load_rdwr (last && (cap_cmd == CMD_RD || cap_cmd == CMD_WR)),
      .load_ref  (last && cap_cmd == CMD_REF),
      .load_bank (cap_bank),
      .req_bank  (req_bank),
      .open_map  (open_map),
      .act_ok    (act_ok),
      .rdwr_ok   (rdwr_ok),
      .ref_ok    (ref_ok),
      .rfc_ok    (rfc_ok)
   );

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= 8'd0;
         tick     <= 2'd0;
         cap_cmd  <= CMD_NOP;
         cap_bank <= 3'd0;
         cap_row  <= 16'd0;
         cap_col  <= 10'd0;
         cs       <= 1'b0;
         ca       <= 6'd0;
         cke      <= 1'b0;
         cmd_err  <= 1'b0;
         busy     <= 1'b1;
      end else begin
         cmd_err <= 1'b0;
         case (state)
            ST_INIT: begin
               if (init_cnt == INIT_LAST) begin
                  state <= ST_IDLE;
                  cke   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  init_cnt <= init_cnt + 8'd1;
               end
            end
            ST_IDLE: begin
               cmd_err <= accept && illegal;
               cs      <= go;
               ca      <= go ? encode_tick(cur_cmd, req_bank, req_row, req_col, 2'd0) : 6'd0;
               busy    <= go;
               if (go) begin
                  state    <= ST_EMIT;
                  tick     <= 2'd1;
                  cap_cmd  <= cur_cmd;
                  cap_bank <= req_bank;
                  cap_row  <= req_row;
                  cap_col  <= req_col;
               end
            end
            ST_EMIT: begin
               // cs marks ticks 0 and 2; tick 0 was driven from IDLE
               cs <= ~tick[0];
               ca <= encode_tick(cap_cmd, cap_bank, cap_row, cap_col, tick);
               if (last) state <= ST_IDLE;
               else      tick  <= tick + 2'd1;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lpddr4_ca_sequencer.sv
// tb/tb_lpddr4_ca_sequencer.sv - directed bench for the LPDDR4 CA sequencer
module tb_lpddr4_ca_sequencer;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_cmd = 3'd0;
   logic [2:0]  req_bank = 3'd0;
   logic [15:0] req_row = 16'd0;
   logic [9:0]  req_col = 10'd0;
   logic        req_ready, cs, cke, cmd_err, busy;
   logic [5:0]  ca;
   int          errors = 0;
   int          checks = 0;
   int          n;

   always #5 ck = ~ck;

   lpddr4_ca_sequencer dut (
      .ck        (ck),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_bank  (req_bank),
      .req_row   (req_row),
      .req_col   (req_col),
      .cs        (cs),
      .ca        (ca),
      .cke       (cke),
      .cmd_err   (cmd_err),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [2:0] c, input logic [2:0] b, input logic [15:0] r,
                          input logic [9:0] col);
      req_valid = 1'b1;
      req_cmd   = c;
      req_bank  = b;
      req_row   = r;
      req_col   = col;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      #1;
      while (req_ready !== 1'b1 && cnt < 400) begin
         cnt++;
         @(negedge ck);
         #1;
      end
   endtask

   task automatic expect_ticks(input string tag, input int nt, input logic [5:0] e0,
                               input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e3);
      logic [5:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < nt; i++) begin
         @(negedge ck);
         if (i == 0) begin
            req_valid = 1'b0;
            req_cmd   = 3'd0;
         end
         chk($sformatf("%s cs t%0d", tag, i), cs, (i % 2 == 0));
         chk($sformatf("%s ca t%0d", tag, i), ca, e[i]);
         chk($sformatf("%s busy t%0d", tag, i), busy, 1'b1);
      end
   endtask

   task automatic check_init(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s cke low c%0d", tag, i), cke, 1'b0);
         chk($sformatf("%s ready low c%0d", tag, i), req_ready, 1'b0);
         chk($sformatf("%s cs low c%0d", tag, i), cs, 1'b0);
         @(negedge ck);
      end
      chk({tag, " cke high"}, cke, 1'b1);
      chk({tag, " busy idle"}, busy, 1'b0);
      chk({tag, " ca des"}, ca, 6'd0);
      #1;
      chk({tag, " ready idle"}, req_ready, 1'b1);
   endtask

   initial begin
      repeat (3) @(negedge ck);
      chk("rst cs", cs, 1'b0);
      chk("rst ca", ca, 6'd0);
      chk("rst cke", cke, 1'b0);
      chk("rst ready", req_ready, 1'b0);
      chk("rst busy", busy, 1'b1);
      chk("rst cmd_err", cmd_err, 1'b0);
      rst = 1'b0;
      check_init("init");

      present(3'd1, 3'd3, 16'hABCD, 10'd0);
      wait_ready(n);
      chk("act wait", n, 0);
      expect_ticks("act", 4, 6'b101001, 6'b100011, 6'b111111, 6'b001101);
      chk("act open map", dut.open_map, 8'h08);

      present(3'd2, 3'd3, 16'd0, 10'h3FC);
      wait_ready(n);
      chk("rd trcd wait", n, 18);
      expect_ticks("rd", 4, 6'b000010, 6'b010011, 6'b110010, 6'b111111);

      present(3'd2, 3'd5, 16'd0, 10'd0);
      wait_ready(n);
      chk("rd closed tccd wait", n, 8);
      @(negedge ck);
      req_valid = 1'b0;
      chk("rd closed cmd_err", cmd_err, 1'b1);
      chk("rd closed cs", cs, 1'b0);
      chk("rd closed ca", ca, 6'd0);
      chk("rd closed busy", busy, 1'b0);
      @(negedge ck);
      chk("rd closed cmd_err pulse", cmd_err, 1'b0);
      chk("rd closed map", dut.open_map, 8'h08);

      present(3'd1, 3'd3, 16'h1234, 10'd0);
      wait_ready(n);
      chk("act open wait", n, 0);
      @(negedge ck);
      req_valid = 1'b0;
      chk("act open cmd_err", cmd_err, 1'b1);
      chk("act open cs", cs, 1'b0);
      @(negedge ck);
      chk("act open cmd_err pulse", cmd_err, 1'b0);

      present(3'd5, 3'd0, 16'd0, 10'd0);
      wait_ready(n);
      chk("prea wait", n, 0);
      expect_ticks("prea", 2, 6'b110000, 6'b000000, 6'd0, 6'd0);
      chk("prea map", dut.open_map, 8'h00);

      present(3'd6, 3'd0, 16'd0, 10'd0);
      wait_ready(n);
      chk("ref trp wait", n, 18);
      expect_ticks("ref", 2, 6'b101000, 6'b000000, 6'd0, 6'd0);

      present(3'd1, 3'd7, 16'hFFFF, 10'd0);
      wait_ready(n);
      chk("act trfc wait", n, 120);
      @(negedge ck);
      req_valid = 1'b0;
      req_cmd   = 3'd0;
      chk("act7 cs t0", cs, 1'b1);
      chk("act7 ca t0", ca, 6'b111101);
      @(posedge ck);
      #1;
      chk("act7 ca t1", ca, 6'b110111);
      rst = 1'b1;
      #1;
      chk("midrst cs", cs, 1'b0);
      chk("midrst ca", ca, 6'd0);
      chk("midrst cke", cke, 1'b0);
      chk("midrst busy", busy, 1'b1);
      chk("midrst ready", req_ready, 1'b0);
      chk("midrst map", dut.open_map, 8'h00);
      @(negedge ck);
      rst = 1'b0;
      check_init("reinit");
      chk("reinit map", dut.open_map, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
